alu_request_arbiter: RTL

- Shares one 4-bit add/subtract ALU between two requesters. The ALU has a registered output and a 2-bit control: 00 = clear, 01 = add, 10 = subtract, 11 = hold.
- Accepts one operation at a time through a valid/ready handshake and sequences the ALU control and operands.
- Captures the result after the ALU's register latency and returns it to the requester that issued it, using a per-requester response handshake.
- Sits between the requesting blocks and the ALU instance, which is instantiated alongside it in the parent.

---
 rtl/alu_request_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_request_arbiter.sv
// Two-requester front end for a shared registered add/subtract ALU: round-robin
// grant, operand/control sequencing, and result return on a per-requester response handshake.
module alu_request_arbiter #(
    parameter int DATA_WIDTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_x,
    input  logic [DATA_WIDTH-1:0] req0_y,
    input  logic                  req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_x,
    input  logic [DATA_WIDTH-1:0] req1_y,
    input  logic                  req1_op,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [DATA_WIDTH-1:0] alu_x,
    output logic [DATA_WIDTH-1:0] alu_y,
    output logic [1:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] CTRL_CLEAR = 2'b00;
    localparam logic [1:0] CTRL_ADD   = 2'b01;
    localparam logic [1:0] CTRL_SUB   = 2'b10;
    localparam logic [1:0] CTRL_HOLD  = 2'b11;

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] alu_x_r, alu_x_s;
    logic [DATA_WIDTH-1:0] alu_y_r, alu_y_s;
    logic [1:0]            alu_ctrl_r, alu_ctrl_s;
    logic [DATA_WIDTH-1:0] resp_data_r, resp_data_s;
    logic                  resp0_valid_r, resp0_valid_s;
    logic                  resp1_valid_r, resp1_valid_s;
    logic                  last_grant_r, last_grant_s;
    logic                  owner_r, owner_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  busy_r, busy_s;
    logic                  gnt0_s, gnt1_s;
    logic                  pick1_s;
    logic                  owner_ready_s;

    // Next-state, grant and register-update decode
    always_comb begin
        state_s       = state_r;
        alu_x_s       = alu_x_r;
        alu_y_s       = alu_y_r;
        alu_ctrl_s    = alu_ctrl_r;
        resp_data_s   = resp_data_r;
        resp0_valid_s = resp0_valid_r;
        resp1_valid_s = resp1_valid_r;
        last_grant_s  = last_grant_r;
        owner_s       = owner_r;
        cnt_s         = cnt_r;
        gnt0_s        = 1'b0;
        gnt1_s        = 1'b0;
        // requester 1 wins when alone, or on a tie when requester 0 won last
        pick1_s       = req1_valid && (!req0_valid || (last_grant_r == 1'b0));
        owner_ready_s = owner_r ? resp1_ready : resp0_ready;

        case (state_r)
            ST_INIT: begin
                // first cycle after reset: issue the clear; second: hold and go idle
                if (alu_ctrl_r == CTRL_HOLD) begin
                    alu_ctrl_s = CTRL_CLEAR;
                end else begin
                    alu_ctrl_s = CTRL_HOLD;
                    state_s    = ST_IDLE;
                end
            end
            ST_IDLE: begin
                alu_ctrl_s = CTRL_HOLD;
                if (req0_valid || req1_valid) begin
                    gnt1_s       = pick1_s;
                    gnt0_s       = !pick1_s;
                    alu_x_s      = pick1_s ? req1_x : req0_x;
                    alu_y_s      = pick1_s ? req1_y : req0_y;
                    alu_ctrl_s   = (pick1_s ? req1_op : req0_op) ? CTRL_SUB : CTRL_ADD;
                    owner_s      = pick1_s;
                    last_grant_s = pick1_s;
                    state_s      = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                alu_ctrl_s = CTRL_HOLD;
                cnt_s      = CNT_LOAD;
                state_s    = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    resp_data_s   = alu_result;
                    resp0_valid_s = !owner_r;
                    resp1_valid_s = owner_r;
                    state_s       = ST_RESP;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (owner_ready_s) begin
                    resp0_valid_s = 1'b0;
                    resp1_valid_s = 1'b0;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                alu_ctrl_s    = CTRL_HOLD;
                resp0_valid_s = 1'b0;
                resp1_valid_s = 1'b0;
                state_s       = ST_INIT;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_INIT;
            alu_x_r       <= {DATA_WIDTH{1'b0}};
            alu_y_r       <= {DATA_WIDTH{1'b0}};
            alu_ctrl_r    <= CTRL_HOLD;
            resp_data_r   <= {DATA_WIDTH{1'b0}};
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
            last_grant_r  <= 1'b1;
            owner_r       <= 1'b0;
            cnt_r         <= CNT_ZERO;
            busy_r        <= 1'b1;
        end else begin
            state_r       <= state_s;
            alu_x_r       <= alu_x_s;
            alu_y_r       <= alu_y_s;
            alu_ctrl_r    <= alu_ctrl_s;
            resp_data_r   <= resp_data_s;
            resp0_valid_r <= resp0_valid_s;
            resp1_valid_r <= resp1_valid_s;
            last_grant_r  <= last_grant_s;
            owner_r       <= owner_s;
            cnt_r         <= cnt_s;
            busy_r        <= busy_s;
        end
    end

    assign req0_ready  = gnt0_s;
    assign req1_ready  = gnt1_s;
    assign resp0_valid = resp0_valid_r;
    assign resp1_valid = resp1_valid_r;
    assign resp_data   = resp_data_r;
    assign alu_x       = alu_x_r;
    assign alu_y       = alu_y_r;
    assign alu_ctrl    = alu_ctrl_r;
    assign busy        = busy_r;

endmodule
